sram_access_ctrl: RTL and testbench

- Initiator-side load/store controller that drives the single-port word-addressed data SRAM (ports Addr, WD, RD, WE, RE; registered read, one-cycle latency; WE and RE both high means no operation).
- Accepts byte/halfword/word load and store requests from the MIPS datapath over a valid/ready handshake.
- Converts byte addresses to word addresses and performs read-modify-write for sub-word stores, because the SRAM has no byte enables.
- Returns load data (sign/zero extended) or store acknowledge over a valid/ready response channel.

---
 rtl/sram_access_ctrl_if.sv | 44 ++++
 rtl/sram_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake plus data-SRAM bus between the datapath and sram_access_ctrl.
// Ports: req_* (valid/ready load/store request), resp_* (valid/ready response),
//        mem_* (single-port word SRAM: Addr, WD, WE, RE, RD), busy status.
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    // request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    // SRAM bus
    logic [ADDR_W-1:0] mem_Addr;
    logic [31:0]       mem_WD;
    logic              mem_WE;
    logic              mem_RE;
    logic [31:0]       mem_RD;
    // status
    logic              busy;

    // controller side
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_Addr, mem_WD, mem_WE, mem_RE, busy
    );

    // datapath / SRAM side
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_Addr, mem_WD, mem_WE, mem_RE, busy
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Load/store controller for a single-port word SRAM without byte enables (RMW for sub-word stores).
// Latency accept->resp_valid: load 3, word store 2, sub-word store 4, error 1 cycles; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: clk, rst_n (async active-low), bus (sram_access_ctrl_if.slave: req_*, resp_*, mem_*, busy).
// Optional: define ALIGN_CHECK_EN to reject misaligned halfword/word requests with resp_err.
module sram_access_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_RSP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // store data; for sub-word stores it is overwritten with the merged word in WT
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_widx;
    logic              req_bad;
    logic [31:0]       rd_shift;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // request validation
    always_comb begin
        req_widx = bus.req_addr >> 2;
        req_bad  = (bus.req_size == 2'b11) || (req_widx >= ADDR_W'(MEM_WORDS));
`ifdef ALIGN_CHECK_EN
        if ((bus.req_size == 2'b01) && bus.req_addr[0])
            req_bad = 1'b1;
        if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            req_bad = 1'b1;
`endif
    end

    // lane extraction / extension for loads, lane insertion for sub-word stores
    always_comb begin
        rd_shift = bus.mem_RD >> {addr_q[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   load_val = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: load_val = bus.mem_RD;
        endcase
        merged = bus.mem_RD;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // next state
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_bad) begin
                        state_d = S_RSP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                if (we_q) begin
                    wdata_d = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_RSP;
                end
            end
            S_WR: state_d = S_RSP;
            S_RSP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.busy       = (state_q != S_IDLE);
        bus.mem_RE     = (state_q == S_RD);
        bus.mem_WE     = (state_q == S_WR);
        bus.mem_Addr   = ((state_q == S_RD) || (state_q == S_WT) || (state_q == S_WR))
                         ? (addr_q >> 2) : '0;
        bus.mem_WD     = (state_q == S_WR) ? wdata_q : 32'h0;
        bus.resp_valid = (state_q == S_RSP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Testbench for sram_access_ctrl: directed requests, expected responses queued at issue time,
// a forked monitor pops and compares on every response handshake and tracks SRAM strobes.
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_access_ctrl_if #(.ADDR_W(32)) bus ();

    sram_access_ctrl #(.ADDR_W(32), .MEM_WORDS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural SRAM: registered read, WE&RE together is a no-op
    logic [31:0] mem [0:31];
    logic [31:0] rd_q;
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[3] <= 32'h80FF0005;
            mem[5] <= 32'h00000008;
            mem[6] <= 32'h11223344;
            rd_q   <= 32'h0;
        end else begin
            if (bus.mem_WE && !bus.mem_RE && bus.mem_Addr < 32)
                mem[bus.mem_Addr[4:0]] <= bus.mem_WD;
            if (bus.mem_RE && !bus.mem_WE && bus.mem_Addr < 32)
                rd_q <= mem[bus.mem_Addr[4:0]];
        end
    end
    assign bus.mem_RD = rd_q;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   re_cnt = 0;
    int   we_cnt = 0;
    int   overlap = 0;
    logic [31:0] last_re_addr = 32'h0;
    logic [31:0] last_we_addr = 32'h0;
    logic [31:0] last_wd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_WE && bus.mem_RE) overlap++;
            if (bus.mem_RE) begin
                re_cnt++;
                last_re_addr = bus.mem_Addr;
            end
            if (bus.mem_WE) begin
                we_cnt++;
                last_we_addr = bus.mem_Addr;
                last_wd      = bus.mem_WD;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                    chk({e.name, "_err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
                end
            end
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_re, input int exp_we, input int hold);
        int   n;
        int   lat;
        int   re0;
        int   we0;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_req_ready"}, {31'h0, bus.req_ready}, 32'd1);
        re0 = re_cnt;
        we0 = we_cnt;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        bus.resp_ready = (hold == 0);
        e.name  = name;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // garbage on the request channel must be ignored while busy
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = 2'b11;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'hDEAD_BEEF;
        lat = 1;
        @(negedge clk);
        while (!bus.resp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, exp_lat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, {31'h0, bus.resp_valid}, 32'd1);
                chk({name, "_hold_rdata"}, bus.resp_rdata, exp_rdata);
                chk({name, "_hold_req_ready"}, {31'h0, bus.req_ready}, 32'd0);
                chk({name, "_hold_busy"}, {31'h0, bus.busy}, 32'd1);
            end
            @(posedge clk); #1;
            bus.resp_ready = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.resp_valid && n < 20);
        chk({name, "_resp_done"}, {31'h0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk({name, "_re_cycles"}, re_cnt - re0, exp_re);
        chk({name, "_we_cycles"}, we_cnt - we0, exp_we);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int we_before;
        rst_n          = 1'b0;
        preload        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_WE}, 32'd0);
        chk("rst_mem_re", {31'h0, bus.mem_RE}, 32'd0);
        chk("rst_mem_addr", bus.mem_Addr, 32'h0);
        chk("rst_mem_wd", bus.mem_WD, 32'h0);
        preload = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        // loads from word3 = 0x80FF0005
        do_req("ld_w3",  1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h80FF0005, 1'b0, 3, 1, 0, 0);
        chk("ld_w3_mem_addr", last_re_addr, 32'd3);
        do_req("ld_b_s", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1, 0, 0);
        do_req("ld_b_u", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 32'h000000FF, 1'b0, 3, 1, 0, 0);
        do_req("ld_h_s", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1, 0, 0);

        // byte store into word5 = 0x00000008, lane 1
        do_req("st_b",   1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AB, 32'h0, 1'b0, 4, 1, 1, 0);
        chk("st_b_mem_wd", last_wd, 32'h0000AB08);
        chk("st_b_mem_addr", last_we_addr, 32'd5);
        do_req("ld_w5",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0000AB08, 1'b0, 3, 1, 0, 0);

        // word store with response backpressure
        do_req("st_w",   1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, 2, 0, 1, 5);
        chk("st_w_mem_addr", last_we_addr, 32'd4);
        chk("st_w_mem_wd", last_wd, 32'h12345678);
        do_req("ld_w4",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 3, 1, 0, 0);

        // halfword store into upper half of word6 = 0x11223344
        do_req("st_h",   1'b1, 2'b01, 1'b0, 32'h1A, 32'h0000BEEF, 32'h0, 1'b0, 4, 1, 1, 0);
        chk("st_h_mem_wd", last_wd, 32'hBEEF3344);
        do_req("ld_h_u", 1'b0, 2'b01, 1'b0, 32'h1A, 32'h0, 32'h0000BEEF, 1'b0, 3, 1, 0, 0);

        // error paths
        do_req("err_rng_ld", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_size",   1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_rng_st", 1'b1, 2'b10, 1'b0, 32'h84, 32'h5A5A5A5A, 32'h0, 1'b1, 1, 0, 0, 0);
`ifdef ALIGN_CHECK_EN
        do_req("misalign_w", 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
`else
        do_req("misalign_w", 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, 32'h80FF0005, 1'b0, 3, 1, 0, 0);
`endif

        // reset during WT of a byte store to word5
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h14;
        bus.req_wdata  = 32'h00000055;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        @(posedge clk); #1;
        chk("rst_wt_mem_addr", bus.mem_Addr, 32'd5);
        chk("rst_wt_mem_re", {31'h0, bus.mem_RE}, 32'd0);
        we_before = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_wt_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_wt_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rst_wt_mem_we", {31'h0, bus.mem_WE}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wt_no_write", we_cnt - we_before, 32'd0);
        chk("rst_wt_mem5", mem[5], 32'h0000AB08);
        chk("rst_wt_no_resp", {31'h0, bus.resp_valid}, 32'd0);
        do_req("ld_w5_after_rst", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0000AB08, 1'b0, 3, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("we_re_overlap", overlap, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
